// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the unified memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_watchdog
// Brief    : Saturating wait counter; flags the last permitted BUSY cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Brief    : Fetch / load-store arbiter for a single unified memory port.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int MAX_STREAK = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                err,
    output logic                timeout_flag,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    arb_state_t          state_q;
    logic                owner_q;
    logic [SW-1:0]       streak_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                tflag_q;
    logic                if_ack_q;
    logic                d_ack_q;

    logic                grant_data;
    logic                wd_expired;

    // Data wins unless fetch has already been passed over MAX_STREAK times.
    assign grant_data = d_req && !(if_req && (streak_q == STREAK_MAX));

    mem_arb_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != ST_BUSY),
        .enable_i  ((state_q == ST_BUSY) && !mem_ready),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tflag_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_data) begin
                        owner_q     <= OWN_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_be_q    <= d_be;
                        state_q     <= ST_BUSY;
                        if (!if_req) begin
                            streak_q <= '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_q <= streak_q + SW'(1);
                        end
                    end else if (if_req) begin
                        owner_q     <= OWN_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '0;
                        state_q     <= ST_BUSY;
                        streak_q    <= '0;
                    end
                end
                ST_BUSY: begin
                    // Acks are registered here so they are high for exactly the DONE cycle.
                    if (mem_ready || wd_expired) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        if_ack_q  <= (owner_q == OWN_IF);
                        d_ack_q   <= (owner_q == OWN_D);
                        if (mem_ready) begin
                            rdata_q <= mem_we_q ? '0 : mem_rdata;
                            err_q   <= 1'b0;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            tflag_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack       = if_ack_q;
    assign d_ack        = d_ack_q;
    assign if_rdata     = rdata_q;
    assign d_rdata      = rdata_q;
    assign err          = err_q;
    assign timeout_flag = tflag_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Brief    : Random-stimulus scoreboard bench for unified_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int TIMEOUT    = 16;
    localparam int MAX_STREAK = 2;
    localparam int ACK_LIMIT  = 60;
    localparam int NEVER      = 100;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    typedef struct packed {
        logic        own_d;
        logic        err;
        logic        tflag;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack, d_req, d_we, d_ack, err, timeout_flag;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   lat_q[$];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem_arr [logic [31:0]];

    bit if_pend, d_pend;
    int streak_m;
    bit tflag_m;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .err(err), .timeout_flag(timeout_flag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h100 + 32'(4 * $urandom_range(0, 7));
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 10) return int'($urandom_range(0, 4));
        if (r < 12) return TIMEOUT - 1;
        if (r < 13) return TIMEOUT;
        return NEVER;
    endfunction

    task automatic new_fetch();
        if_pend = 1'b1;
        if_addr = rand_addr();
    endtask

    task automatic new_data();
        d_pend  = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(1, 15));
    endtask

    // Reference: decide the winner from the pending set, predict the response, run to IDLE.
    task automatic do_round(input int lat);
        bit   win_d;
        bus_t b;
        exp_t e;
        int   cyc;
        if_req = if_pend;
        d_req  = d_pend;
        win_d  = d_pend && !(if_pend && streak_m == MAX_STREAK);
        if (win_d) streak_m = if_pend ? ((streak_m < MAX_STREAK) ? streak_m + 1 : MAX_STREAK) : 0;
        else       streak_m = 0;
        b.we    = win_d ? d_we : 1'b0;
        b.addr  = win_d ? d_addr : if_addr;
        b.wdata = (win_d && d_we) ? d_wdata : 32'h0;
        b.be    = win_d ? d_be : 4'h0;
        e.own_d = win_d;
        e.err   = (lat >= TIMEOUT);
        if (e.err) tflag_m = 1'b1;
        e.tflag = tflag_m;
        e.rdata = (e.err || b.we) ? 32'h0
                : (ref_mem.exists(b.addr) ? ref_mem[b.addr] : init_word(b.addr));
        if (!e.err && b.we)
            ref_mem[b.addr] = merge(ref_mem.exists(b.addr) ? ref_mem[b.addr] : init_word(b.addr),
                                    b.wdata, b.be);
        exp_q.push_back(e);
        bus_q.push_back(b);
        lat_q.push_back(lat);
        @(posedge clk);
        @(negedge clk);
        check("grant_latency", 64'(mem_req), 64'd1);
        cyc = 0;
        while (!(if_ack || d_ack) && cyc < ACK_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= ACK_LIMIT) begin
            n_fail++;
            $display("FAIL ack_wait: no ack after %0d cycles, required within %0d", cyc, ACK_LIMIT);
        end
        @(posedge clk);
        #1;
        if (win_d) begin d_pend = 1'b0; d_req = 1'b0; end
        else       begin if_pend = 1'b0; if_req = 1'b0; end
    endtask

    // Memory model: serves the bus in order using the latency chosen at issue time.
    initial begin : responder
        bit   active;
        bus_t cur;
        int   cur_lat, k, exp_k;
        active    = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        cur       = '0;
        cur_lat   = 0;
        k         = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active    = 1'b0;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    k      = 0;
                    n_checks++;
                    if (lat_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL bus_unexpected: mem_req with no issued transaction");
                        cur_lat = NEVER;
                        cur     = '0;
                    end else begin
                        cur_lat = lat_q.pop_front();
                        cur     = bus_q.pop_front();
                    end
                end
                check("bus_fields", {27'h0, mem_we, mem_addr, mem_be}, {27'h0, cur.we, cur.addr, cur.be});
                if (cur.we) check("bus_wdata", 64'(mem_wdata), 64'(cur.wdata));
                mem_ready = (k == cur_lat);
                mem_rdata = $urandom;
                if (mem_ready && !mem_we)
                    mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
                if (mem_ready && mem_we)
                    mem_arr[mem_addr] = merge(mem_arr.exists(mem_addr) ? mem_arr[mem_addr]
                                              : init_word(mem_addr), mem_wdata, mem_be);
                k++;
            end else begin
                if (active) begin
                    exp_k = (cur_lat < TIMEOUT) ? cur_lat + 1 : TIMEOUT;
                    check("mem_req_cycles", 64'(k), 64'(exp_k));
                    active = 1'b0;
                end
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && (if_ack || d_ack)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: if_ack=%0b d_ack=%0b with nothing outstanding",
                             if_ack, d_ack);
                end else begin
                    e = exp_q.pop_front();
                    check("single_ack", 64'(if_ack & d_ack), 64'd0);
                    check("ack_owner", 64'(d_ack), 64'(e.own_d));
                    check("ack_rdata", 64'(e.own_d ? d_rdata : if_rdata), 64'(e.rdata));
                    check("ack_err", 64'(err), 64'(e.err));
                    check("timeout_flag", 64'(timeout_flag), 64'(e.tflag));
                    check("ack_timing", {62'h0, prev_req, mem_req}, 64'b10);
                end
            end
            prev_req = mem_req;
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        reset   = 1'b1;
        if_req  = 1'b0;  if_addr = 32'h0;
        d_req   = 1'b0;  d_we    = 1'b0;  d_addr = 32'h0;  d_wdata = 32'h0;  d_be = 4'h0;
        if_pend = 1'b0;  d_pend  = 1'b0;  streak_m = 0;    tflag_m = 1'b0;
        ref_mem[32'h100] = 32'h0050_0093;
        mem_arr[32'h100] = 32'h0050_0093;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {58'h0, mem_req, mem_we, if_ack, d_ack, err, timeout_flag}, 64'd0);
        check("reset_data", {mem_addr, if_rdata}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Lone fetch with zero-wait memory, then a lone store held for three wait cycles.
        if_pend = 1'b1; if_addr = 32'h100;
        do_round(0);
        d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
        do_round(3);

        // Both requesters always pending: expect D, D, IF, D, D, IF.
        for (int i = 0; i < 6; i++) begin
            if (!if_pend) new_fetch();
            if (!d_pend)  new_data();
            do_round(int'($urandom_range(0, 2)));
        end
        while (if_pend || d_pend) do_round(int'($urandom_range(0, 2)));

        // Reset while BUSY: the transaction is abandoned with no ack.
        if_addr = rand_addr();
        if_req  = 1'b1;
        bus_q.push_back('{we: 1'b0, addr: if_addr, wdata: 32'h0, be: 4'h0});
        lat_q.push_back(NEVER);
        repeat (6) @(posedge clk);
        #1;
        reset  = 1'b1;
        if_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {61'h0, mem_req, if_ack | d_ack, timeout_flag}, 64'd0);
        streak_m = 0;
        tflag_m  = 1'b0;
        bus_q.delete();
        lat_q.delete();
        repeat (3) @(negedge clk);
        if_pend = 1'b1; if_addr = rand_addr();
        do_round(1);

        // Random traffic, including timeouts, last-cycle ready and idle gaps.
        for (int i = 0; i < 150; i++) begin
            if (!if_pend && !d_pend && $urandom_range(0, 4) == 0) begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
            if (!if_pend && $urandom_range(0, 2) != 0) new_fetch();
            if (!d_pend && ($urandom_range(0, 2) != 0 || !if_pend)) new_data();
            do_round(rand_lat());
        end
        while (if_pend || d_pend) do_round(int'($urandom_range(0, 4)));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size() + lat_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
